// File: rtl/vga_pkg.sv
// Shared definitions for the VGA frame-buffer datapath.
// Contents: frame geometry, frame-buffer address and pixel widths, RGB555
// field positions, and the encoding of the RAM command stage.
package vga_pkg;

    localparam int H_ACTIVE  = 320;
    localparam int V_ACTIVE  = 240;

    // 320 x 240 = 76800 words, so 17 address bits.
    localparam int FB_ADDR_W = 17;
    localparam int PIX_W     = 15;

    // Pixel packing R[14:10] G[9:5] B[4:0].
    localparam int R_MSB = 14;
    localparam int R_LSB = 10;
    localparam int G_MSB = 9;
    localparam int G_LSB = 5;
    localparam int B_MSB = 4;
    localparam int B_LSB = 0;

    // Command that the RAM port carries in a given cycle.
    typedef enum logic [1:0] {
        CMD_IDLE = 2'd0,
        CMD_RD   = 2'd1,
        CMD_WR   = 2'd2
    } mem_cmd_e;

endpackage : vga_pkg

// File: rtl/wbuf_fifo.sv
// Small synchronous FIFO used as the posted-write buffer for drawing writes.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   push_i        write push_data_i into the tail (ignored when full)
//   push_data_i   entry to store
//   pop_i         drop the head entry (ignored when empty)
//   head_o        current head entry, readable in the same cycle
//   level_o       occupancy, 0..DEPTH
//   full_o        level_o == DEPTH
//   empty_o       level_o == 0
module wbuf_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(DEPTH);

    logic [WIDTH-1:0] store_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0] level_q, level_d;
    logic             push_ok, pop_ok;

    assign full_o  = (level_q == DEPTH_L);
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign head_o  = store_q[rd_ptr_q];

    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    // Level is tracked separately so the pointers can wrap naturally and
    // full/empty never need an extra pointer bit.
    always_comb begin
        level_d = level_q;
        if (push_ok && !pop_ok) begin
            level_d = level_q + 1'b1;
        end else if (!push_ok && pop_ok) begin
            level_d = level_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            level_q <= level_d;
        end
    end

    // Storage carries no reset; stale entries are unreachable once the
    // pointers and level are cleared.
    always_ff @(posedge clk) begin
        if (push_ok) store_q[wr_ptr_q] <= push_data_i;
    end

endmodule : wbuf_fifo

// File: rtl/vga_fb_arbiter.sv
// Arbiter sharing one single-port frame-buffer RAM between VGA scan-out reads
// (absolute priority, fixed 2-cycle latency) and drawing-engine writes
// (posted through a small FIFO, drained in cycles scan-out leaves free).
// Ports:
//   clk, rst                          clock, asynchronous active-high reset
//   disp_req_i, disp_addr_i           scan-out read request pulse + address
//   disp_valid_o, disp_data_o         read return, 2 cycles after disp_req_i
//   wr_valid_i, wr_ready_o            drawing write handshake
//   wr_addr_i, wr_data_i              drawing write address / pixel
//   mem_en_o, mem_we_o                registered RAM strobe / write enable
//   mem_addr_o, mem_wdata_o           registered RAM address / write data
//   mem_rdata_i                       RAM read data, 1 cycle after a read strobe
//   wbuf_level_o                      write-buffer occupancy
//   starve_o                          sticky: a buffered write waited too long
module vga_fb_arbiter
    import vga_pkg::*;
#(
    parameter int ADDR_W       = FB_ADDR_W,
    parameter int DATA_W       = PIX_W,
    parameter int WBUF_DEPTH   = 4,
    parameter int STARVE_LIMIT = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          disp_req_i,
    input  logic [ADDR_W-1:0]             disp_addr_i,
    output logic                          disp_valid_o,
    output logic [DATA_W-1:0]             disp_data_o,
    input  logic                          wr_valid_i,
    output logic                          wr_ready_o,
    input  logic [ADDR_W-1:0]             wr_addr_i,
    input  logic [DATA_W-1:0]             wr_data_i,
    output logic                          mem_en_o,
    output logic                          mem_we_o,
    output logic [ADDR_W-1:0]             mem_addr_o,
    output logic [DATA_W-1:0]             mem_wdata_o,
    input  logic [DATA_W-1:0]             mem_rdata_i,
    output logic [$clog2(WBUF_DEPTH):0]   wbuf_level_o,
    output logic                          starve_o
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT_L = CNT_W'(STARVE_LIMIT);

    logic [ADDR_W+DATA_W-1:0] head;
    logic                     fifo_full, fifo_empty;
    logic                     push, pop;
    mem_cmd_e                 cmd_d;

    logic                     mem_en_q, mem_we_q;
    logic [ADDR_W-1:0]        mem_addr_q;
    logic [DATA_W-1:0]        mem_wdata_q;
    logic                     disp_valid_q;
    logic [CNT_W-1:0]         starve_cnt_q, starve_cnt_d;
    logic                     starve_q;

    // Ready comes only from the registered level: a pop in the same cycle
    // does not open a slot until the next cycle.
    assign wr_ready_o = !fifo_full;
    assign push       = wr_valid_i && wr_ready_o;
    assign pop        = (cmd_d == CMD_WR);

    wbuf_fifo #(
        .WIDTH (ADDR_W + DATA_W),
        .DEPTH (WBUF_DEPTH)
    ) u_wbuf (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .push_data_i ({wr_addr_i, wr_data_i}),
        .pop_i       (pop),
        .head_o      (head),
        .level_o     (wbuf_level_o),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    // Scan-out always wins; the buffer head drains only in free cycles.
    always_comb begin
        cmd_d = CMD_IDLE;
        if (disp_req_i) begin
            cmd_d = CMD_RD;
        end else if (!fifo_empty) begin
            cmd_d = CMD_WR;
        end
    end

    // The counter only runs while a write is pending and blocked, and
    // saturates at the limit so it cannot wrap and look healthy again.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (pop) begin
            starve_cnt_d = '0;
        end else if (!fifo_empty && (starve_cnt_q != LIMIT_L)) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            disp_valid_q <= 1'b0;
            starve_cnt_q <= '0;
            starve_q     <= 1'b0;
        end else begin
            mem_en_q <= (cmd_d != CMD_IDLE);
            mem_we_q <= (cmd_d == CMD_WR);
            case (cmd_d)
                CMD_RD: begin
                    mem_addr_q <= disp_addr_i;
                end
                CMD_WR: begin
                    mem_addr_q  <= head[ADDR_W+DATA_W-1:DATA_W];
                    mem_wdata_q <= head[DATA_W-1:0];
                end
                default: begin
                    // Idle: hold the bus to avoid needless toggling.
                end
            endcase
            // A read strobe on the bus now returns data next cycle.
            disp_valid_q <= mem_en_q && !mem_we_q;
            starve_cnt_q <= starve_cnt_d;
            starve_q     <= starve_q || (starve_cnt_d == LIMIT_L);
        end
    end

    assign mem_en_o    = mem_en_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign starve_o    = starve_q;
    assign disp_valid_o = disp_valid_q;

    // The RAM's own output register is the pixel register of this path, so
    // re-registering it would cost the fixed 2-cycle latency. The data is
    // masked outside valid cycles so the port idles at zero.
    assign disp_data_o = disp_valid_q ? mem_rdata_i : '0;

endmodule : vga_fb_arbiter

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter with a synchronous-read RAM model.
module tb_vga_fb_arbiter;

    localparam int AW = 17;
    localparam int DW = 15;
    localparam int LW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          disp_req = 1'b0;
    logic [AW-1:0] disp_addr = '0;
    logic          disp_valid;
    logic [DW-1:0] disp_data;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic [LW-1:0] wbuf_level;
    logic          starve;

    int n_checks = 0;
    int n_errors = 0;

    logic [DW-1:0] ram [0:(1<<AW)-1];

    vga_fb_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .WBUF_DEPTH(4), .STARVE_LIMIT(64)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .disp_req_i   (disp_req),
        .disp_addr_i  (disp_addr),
        .disp_valid_o (disp_valid),
        .disp_data_o  (disp_data),
        .wr_valid_i   (wr_valid),
        .wr_ready_o   (wr_ready),
        .wr_addr_i    (wr_addr),
        .wr_data_i    (wr_data),
        .mem_en_o     (mem_en),
        .mem_we_o     (mem_we),
        .mem_addr_o   (mem_addr),
        .mem_wdata_o  (mem_wdata),
        .mem_rdata_i  (mem_rdata),
        .wbuf_level_o (wbuf_level),
        .starve_o     (starve)
    );

    always #10 clk = ~clk;

    // Single-port RAM: write on strobe+we, registered read data otherwise.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata <= ram[mem_addr];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    int acc;
    int lvl3 [16] = '{1, 2, 3, 4, 4, 4, 4, 4, 4, 4, 3, 3, 3, 2, 1, 0};
    bit acc3 [16] = '{1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0};

    initial begin
        // Reset state
        tick();
        tick();
        check_val("rst_disp_valid", 32'(disp_valid), 0);
        check_val("rst_disp_data",  32'(disp_data), 0);
        check_val("rst_wr_ready",   32'(wr_ready), 1);
        check_val("rst_mem_en",     32'(mem_en), 0);
        check_val("rst_mem_we",     32'(mem_we), 0);
        check_val("rst_mem_addr",   32'(mem_addr), 0);
        check_val("rst_mem_wdata",  32'(mem_wdata), 0);
        check_val("rst_level",      32'(wbuf_level), 0);
        check_val("rst_starve",     32'(starve), 0);
        rst = 1'b0;
        tick();

        // Preload RAM[0x10] = 0x7C00 through the write path.
        wr_valid = 1'b1; wr_addr = 17'h00010; wr_data = 15'h7C00;
        tick();
        wr_valid = 1'b0;
        check_val("pre_level", 32'(wbuf_level), 1);
        check_val("pre_en_min_latency", 32'(mem_en), 0);
        tick();
        check_val("pre_we", 32'(mem_we), 1);
        check_val("pre_addr", 32'(mem_addr), 32'h10);
        tick();

        // Test 1: single read, 2-cycle latency
        disp_req = 1'b1; disp_addr = 17'h00010;
        tick();
        disp_req = 1'b0;
        check_val("t1_en", 32'(mem_en), 1);
        check_val("t1_we", 32'(mem_we), 0);
        check_val("t1_addr", 32'(mem_addr), 32'h10);
        check_val("t1_valid_early", 32'(disp_valid), 0);
        tick();
        check_val("t1_valid", 32'(disp_valid), 1);
        check_val("t1_data", 32'(disp_data), 32'h7C00);
        tick();
        check_val("t1_valid_late", 32'(disp_valid), 0);

        // Test 2: four streamed writes, no display traffic
        for (int i = 0; i < 5; i++) begin
            wr_valid = (i < 4); wr_addr = AW'(i); wr_data = 15'h001F;
            tick();
            check_val($sformatf("t2_level%0d", i), 32'(wbuf_level), (i < 4) ? 1 : 0);
            if (i >= 1) begin
                check_val($sformatf("t2_we%0d", i), 32'(mem_en && mem_we), 1);
                check_val($sformatf("t2_addr%0d", i), 32'(mem_addr), 32'(i - 1));
                check_val($sformatf("t2_wdata%0d", i), 32'(mem_wdata), 32'h1F);
            end
        end
        wr_valid = 1'b0;
        tick();
        // Read back addresses 0..3, fully pipelined.
        for (int j = 0; j < 5; j++) begin
            disp_req = (j < 4); disp_addr = AW'(j);
            tick();
            if (j >= 1) begin
                check_val($sformatf("t2_rd_valid%0d", j - 1), 32'(disp_valid), 1);
                check_val($sformatf("t2_rd_data%0d", j - 1), 32'(disp_data), 32'h1F);
            end
        end
        disp_req = 1'b0;
        tick();

        // Test 3: 10-cycle read burst, 6 writes offered
        acc = 0;
        for (int c = 0; c < 16; c++) begin
            disp_req = (c < 10); disp_addr = 17'h00200;
            wr_valid = (acc < 6); wr_addr = AW'(32'h100 + acc); wr_data = DW'(32'h400 + acc);
            check_val($sformatf("t3_ready%0d", c), 32'(wr_ready), ((c == 0 ? 0 : lvl3[c-1]) < 4) ? 1 : 0);
            tick();
            if (acc3[c]) acc++;
            check_val($sformatf("t3_level%0d", c), 32'(wbuf_level), 32'(lvl3[c]));
            if (c < 10) begin
                check_val($sformatf("t3_rd_we%0d", c), {31'd0, mem_we}, 0);
                check_val($sformatf("t3_rd_addr%0d", c), 32'(mem_addr), 32'h200);
            end else begin
                check_val($sformatf("t3_wr_we%0d", c), 32'(mem_en && mem_we), 1);
                check_val($sformatf("t3_wr_addr%0d", c), 32'(mem_addr), 32'(32'h100 + c - 10));
                check_val($sformatf("t3_wr_data%0d", c), 32'(mem_wdata), 32'(32'h400 + c - 10));
            end
        end
        wr_valid = 1'b0;
        disp_req = 1'b0;
        tick();

        // Test 5: full buffer, pop and blocked push in the same cycle
        for (int i = 0; i < 4; i++) begin
            disp_req = 1'b1; wr_valid = 1'b1;
            wr_addr = AW'(32'h300 + i); wr_data = DW'(32'h300 + i);
            tick();
            check_val($sformatf("t5_fill%0d", i), 32'(wbuf_level), 32'(i + 1));
        end
        disp_req = 1'b0; wr_addr = 17'h00304; wr_data = 15'h0304;
        check_val("t5_full_ready", 32'(wr_ready), 0);
        tick();
        check_val("t5_pop_level", 32'(wbuf_level), 3);
        check_val("t5_pop_we", 32'(mem_we), 1);
        check_val("t5_pop_addr", 32'(mem_addr), 32'h300);
        disp_req = 1'b1;
        check_val("t5_ready_again", 32'(wr_ready), 1);
        tick();
        check_val("t5_push_level", 32'(wbuf_level), 4);
        check_val("t5_rd_we", 32'(mem_we), 0);
        wr_valid = 1'b0; disp_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_val($sformatf("t5_drain_addr%0d", i), 32'(mem_addr), 32'(32'h301 + i));
            check_val($sformatf("t5_drain_data%0d", i), 32'(mem_wdata), 32'(32'h301 + i));
        end
        check_val("t5_empty", 32'(wbuf_level), 0);
        tick();

        // Test 4: starvation under a 70-cycle read burst
        disp_req = 1'b1; disp_addr = 17'h00020;
        wr_valid = 1'b1; wr_addr = 17'h003FF; wr_data = 15'h1234;
        tick();
        wr_valid = 1'b0;
        check_val("t4_level", 32'(wbuf_level), 1);
        check_val("t4_starve0", 32'(starve), 0);
        for (int k = 1; k < 70; k++) begin
            tick();
            if (k == 63) check_val("t4_starve_63", 32'(starve), 0);
            if (k == 64) check_val("t4_starve_64", 32'(starve), 1);
        end
        check_val("t4_no_write", 32'(mem_we), 0);
        disp_req = 1'b0;
        tick();
        check_val("t4_drain_we", 32'(mem_we), 1);
        check_val("t4_drain_addr", 32'(mem_addr), 32'h3FF);
        check_val("t4_drain_level", 32'(wbuf_level), 0);
        tick();
        check_val("t4_sticky", 32'(starve), 1);
        rst = 1'b1;
        #1;
        check_val("t4_rst_clear", 32'(starve), 0);
        tick();
        rst = 1'b0;
        tick();

        // Test 6: reset with a read in flight and 3 writes buffered
        for (int i = 0; i < 3; i++) begin
            disp_req = 1'b1; disp_addr = 17'h00010;
            wr_valid = 1'b1; wr_addr = AW'(32'h50 + i); wr_data = 15'h2222;
            tick();
        end
        wr_valid = 1'b0;
        tick();
        check_val("t6_pre_level", 32'(wbuf_level), 3);
        check_val("t6_pre_rd", 32'(mem_en && !mem_we), 1);
        disp_req = 1'b0;
        rst = 1'b1;
        #1;
        check_val("t6_en", 32'(mem_en), 0);
        check_val("t6_level", 32'(wbuf_level), 0);
        check_val("t6_ready", 32'(wr_ready), 1);
        tick();
        check_val("t6_valid_rst", 32'(disp_valid), 0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_val($sformatf("t6_valid%0d", i), 32'(disp_valid), 0);
            check_val($sformatf("t6_mem_en%0d", i), 32'(mem_en), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_vga_fb_arbiter

// File: doc/vga_fb_arbiter.md
Name: vga_fb_arbiter

Overview:
- Shares one single-port frame-buffer RAM between two requesters:
  - the VGA scan-out path, which reads pixels with real-time priority;
  - the drawing engine, which writes pixels through a small posted-write buffer.
- Sits between the pixel timing/scan-out logic and the frame-buffer memory, below mojo_top.
- Guarantees fixed read latency for scan-out. Drawing writes drain only in cycles not taken by scan-out.

Parameters:
- ADDR_W, 17, frame-buffer word address width (320x240 = 76800 pixels).
- DATA_W, 15, pixel width, packed R[14:10] G[9:5] B[4:0], 5 bits per colour.
- WBUF_DEPTH, 4, posted-write buffer entries; power of two, 2..16.
- STARVE_LIMIT, 64, cycles a buffered write may wait before the starve flag sets.

Ports:
- clk  in  1  single clock, 50 MHz.
- rst  in  1  asynchronous, active-high reset.
- disp_req  in  1  scan-out read request, single-cycle pulse; no back-pressure.
- disp_addr  in  ADDR_W  read address, valid with disp_req.
- disp_valid  out  1  read data valid, exactly 2 cycles after disp_req.
- disp_data  out  DATA_W  read pixel, valid with disp_valid.
- wr_valid  in  1  draw write request.
- wr_ready  out  1  buffer can accept a write.
- wr_addr  in  ADDR_W  draw write address.
- wr_data  in  DATA_W  draw write pixel.
- mem_en  out  1  RAM access strobe.
- mem_we  out  1  RAM write enable, qualified by mem_en.
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  DATA_W  RAM write data.
- mem_rdata  in  DATA_W  RAM read data; valid 1 cycle after a read strobe.
- wbuf_level  out  $clog2(WBUF_DEPTH)+1  current buffer occupancy.
- starve  out  1  sticky flag: a write waited STARVE_LIMIT cycles.

Behaviour:
- Reset values: all outputs 0, except wr_ready=1. Buffer empty, starve counter 0.
- Reset mid-operation discards buffered writes and any in-flight read; disp_valid is not issued for it.
- Memory command stage is registered; mem_* outputs change on the clk edge.
- Arbitration per cycle, evaluated on the current inputs:
  - disp_req=1: next cycle issues a read (mem_en=1, mem_we=0, mem_addr=disp_addr). Display always wins.
  - else buffer non-empty: next cycle issues a write of the buffer head (mem_en=1, mem_we=1) and pops the head in the same edge.
  - else: mem_en=0.
- Read pipeline:
  - cycle T: disp_req sampled.
  - T+1: read strobe on mem_*.
  - T+2: disp_valid=1 and disp_data registered from mem_rdata.
  - Back-to-back disp_req on every cycle is legal and fully pipelined; writes then stall indefinitely.
- Write handshake:
  - Transfer occurs when wr_valid && wr_ready on the edge.
  - wr_ready = (level < WBUF_DEPTH), computed from registered level.
  - When full, wr_ready=0 even if a pop happens that cycle. No same-cycle bypass at full.
  - Push and pop in the same cycle leave the level unchanged.
  - A push to an empty buffer is eligible for issue on the following cycle, so minimum write latency is 2 cycles to mem_en.
- Pointers are log2(WBUF_DEPTH) bits and wrap naturally. Level is a separate counter, 0..WBUF_DEPTH.
- Ordering:
  - writes retire in FIFO order;
  - reads never reorder relative to each other;
  - no read-after-write forwarding: a display read of an address still in the buffer returns the old RAM contents. This is accepted as one-frame tearing.
- Starvation monitor:
  - counter increments each cycle the buffer is non-empty and no write is issued;
  - counter clears on each write issue;
  - at STARVE_LIMIT, starve sets and holds until rst. The counter saturates.
- Simultaneous disp_req and a full buffer: the read wins. wr_ready stays 0, with no data loss.

Decomposition:
- Shared package vga_pkg:
  - frame geometry constants H_ACTIVE=320, V_ACTIVE=240;
  - FB_ADDR_W, PIX_W;
  - colour field slice constants;
  - mem command encoding constants (IDLE, RD, WR).
- One sub-module, wbuf_fifo:
  - parameterised sync FIFO holding {addr,data}, with push, pop, head, level and full/empty.
  - The arbiter instantiates it once and holds the command stage, read pipeline and starve monitor.

Test Plan:
1. Reset, then a single disp_req with disp_addr=0x00010 and RAM[0x10]=0x7C00 -> mem_en/mem_we=1/0 at T+1; disp_valid=1 with disp_data=0x7C00 at T+2 only.
2. Four writes (addr 0..3, data 0x001F) with no display traffic -> wbuf_level peaks at 1; mem_we pulses for addr 0,1,2,3 in order; RAM holds 0x001F at each.
3. disp_req held high 10 cycles with 6 writes offered -> 4 accepted, wr_ready=0 afterwards, no mem_we during the burst; the 4 writes drain in the 4 cycles after the burst ends, then the remaining 2 are accepted.
4. disp_req held high 70 cycles with one buffered write -> starve=1 from cycle 64 of waiting and stays 1 after the write drains; rst clears it.
5. Full buffer, wr_valid=1, pop in the same cycle -> no push that cycle; level goes 4->3, and the push lands next cycle, returning level to 4.
6. Assert rst during a read in flight with 3 writes buffered -> no disp_valid, no further mem_en, wbuf_level=0, wr_ready=1.
